// File: rtl/dof_ctrl_pkg.sv
// Shared encodings for the DOF hazard controller: FSM states, the memory-load
// result-source code, NOP control-field values and the control-bundle struct.
package dof_ctrl_pkg;

  localparam logic [1:0] ST_RUN        = 2'b00;
  localparam logic [1:0] ST_LOAD_STALL = 2'b01;
  localparam logic [1:0] ST_BR_FLUSH   = 2'b10;

  localparam logic [1:0] MD_MEM = 2'b01;

  // Field values the DOF output registers load when a bubble is injected.
  localparam logic       RW_NOP = 1'b0;
  localparam logic       MW_NOP = 1'b0;
  localparam logic [1:0] BS_NOP = 2'b00;

  typedef struct packed {
    logic pc_hold;
    logic ir_hold;
    logic dof_bubble;
    logic if_flush;
    logic dof_flush;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{default: 1'b0};

endpackage

// File: rtl/dof_hazard_controller_hazard_detect.sv
// Combinational load-use detector: a memory load in EXE whose destination is
// read by the instruction in DOF through a register-file port.
module hazard_detect
  import dof_ctrl_pkg::*;
#(
  parameter int reg_addr_width = 5
) (
  input  logic                      dof_valid,
  input  logic [reg_addr_width-1:0] AA,
  input  logic [reg_addr_width-1:0] BA,
  input  logic                      MA,
  input  logic                      MB,
  input  logic                      exe_valid,
  input  logic [reg_addr_width-1:0] DA_EXE,
  input  logic                      RW_EXE,
  input  logic [1:0]                MD_EXE,
  output logic                      lu
);

  logic a_hit;
  logic b_hit;
  logic exe_load;

  always_comb begin
    // A port bypassed to PC or B port bypassed to a constant reads no register.
    a_hit    = (AA == DA_EXE) & ~MA;
    b_hit    = (BA == DA_EXE) & ~MB;
    exe_load = exe_valid & RW_EXE & (MD_EXE == MD_MEM) & (DA_EXE != '0);
    lu       = dof_valid & exe_load & (a_hit | b_hit);
  end

endmodule

// File: rtl/dof_hazard_controller.sv
// DOF hazard sequencer: load-use stalls, taken-branch flushes, external freeze.
// Optional HAZARD_PERF_EN adds saturating stall_cycles/flush_events counters.
module dof_hazard_controller
  import dof_ctrl_pkg::*;
#(
  parameter int reg_addr_width = 5,
  parameter int LOAD_LATENCY   = 2,
  parameter int BRANCH_SHADOW  = 2,
  parameter int CNT_WIDTH      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dof_valid,
  input  logic [reg_addr_width-1:0] AA,
  input  logic [reg_addr_width-1:0] BA,
  input  logic                      MA,
  input  logic                      MB,
  input  logic                      exe_valid,
  input  logic [reg_addr_width-1:0] DA_EXE,
  input  logic                      RW_EXE,
  input  logic [1:0]                MD_EXE,
  input  logic                      branch_taken,
  input  logic                      ext_stall,
  output logic                      pc_hold,
  output logic                      ir_hold,
  output logic                      dof_bubble,
  output logic                      if_flush,
  output logic                      dof_flush,
`ifdef HAZARD_PERF_EN
  output logic [15:0]               stall_cycles,
  output logic [15:0]               flush_events,
`endif
  output logic [1:0]                state
);

  localparam logic [CNT_WIDTH-1:0] LOAD_INIT = CNT_WIDTH'(LOAD_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] BR_INIT   = CNT_WIDTH'(BRANCH_SHADOW - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 lu;
  logic                 flush_entry;
  ctl_t                 ctl;

  hazard_detect #(.reg_addr_width(reg_addr_width)) u_hazard_detect (
    .dof_valid (dof_valid),
    .AA        (AA),
    .BA        (BA),
    .MA        (MA),
    .MB        (MB),
    .exe_valid (exe_valid),
    .DA_EXE    (DA_EXE),
    .RW_EXE    (RW_EXE),
    .MD_EXE    (MD_EXE),
    .lu        (lu)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctl         = CTL_IDLE;
    flush_entry = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ext_stall) begin
          ctl.pc_hold = 1'b1;
          ctl.ir_hold = 1'b1;
        end else if (branch_taken && exe_valid) begin
          // Wrong-path DOF instruction is discarded, so a concurrent lu is moot.
          ctl.if_flush    = 1'b1;
          ctl.dof_flush   = 1'b1;
          ctl.dof_bubble  = 1'b1;
          flush_entry     = 1'b1;
          if (BRANCH_SHADOW > 1) begin
            state_d = ST_BR_FLUSH;
            cnt_d   = BR_INIT;
          end
        end else if (lu) begin
          ctl.pc_hold    = 1'b1;
          ctl.ir_hold    = 1'b1;
          ctl.dof_bubble = 1'b1;
          if (LOAD_LATENCY > 1) begin
            state_d = ST_LOAD_STALL;
            cnt_d   = LOAD_INIT;
          end
        end
      end
      ST_LOAD_STALL: begin
        ctl.pc_hold    = 1'b1;
        ctl.ir_hold    = 1'b1;
        ctl.dof_bubble = 1'b1;
        if (!ext_stall) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q <= CNT_ONE) state_d = ST_RUN;
        end
      end
      ST_BR_FLUSH: begin
        ctl.if_flush   = 1'b1;
        ctl.dof_bubble = 1'b1;
        if (ext_stall) begin
          ctl.pc_hold = 1'b1;
          ctl.ir_hold = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q <= CNT_ONE) state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
    // Reset cycle drives no pipeline controls regardless of the current state.
    if (rst) begin
      ctl         = CTL_IDLE;
      flush_entry = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_hold    = ctl.pc_hold;
  assign ir_hold    = ctl.ir_hold;
  assign dof_bubble = ctl.dof_bubble;
  assign if_flush   = ctl.if_flush;
  assign dof_flush  = ctl.dof_flush;
  assign state      = state_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (ctl.pc_hold && stall_cycles_q != 16'hFFFF) stall_cycles_d = stall_cycles_q + 16'd1;
    if (flush_entry && flush_events_q != 16'hFFFF) flush_events_d = flush_events_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  logic unused_flush_entry;
  assign unused_flush_entry = flush_entry;
`endif

endmodule

// File: tb/tb_dof_hazard_controller.sv
// Bench for dof_hazard_controller: directed plan steps plus random traffic
// checked against a remaining-cycles reference model.
module tb_dof_hazard_controller;

  localparam int RAW = 5;
  localparam int LL  = 2;
  localparam int BS  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           dof_valid;
  logic [RAW-1:0] AA, BA, DA_EXE;
  logic           MA, MB, exe_valid, RW_EXE;
  logic [1:0]     MD_EXE;
  logic           branch_taken, ext_stall;
  logic           pc_hold, ir_hold, dof_bubble, if_flush, dof_flush;
  logic [1:0]     state;
`ifdef HAZARD_PERF_EN
  logic [15:0]    stall_cycles, flush_events;
`endif

  int vectors    = 0;
  int miscompares = 0;
  int hold_cnt   = 0;
  int m_stall_left = 0;
  int m_flush_left = 0;

  always #5 clk = ~clk;

  dof_hazard_controller #(
    .reg_addr_width(RAW), .LOAD_LATENCY(LL), .BRANCH_SHADOW(BS), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst), .dof_valid(dof_valid), .AA(AA), .BA(BA), .MA(MA), .MB(MB),
    .exe_valid(exe_valid), .DA_EXE(DA_EXE), .RW_EXE(RW_EXE), .MD_EXE(MD_EXE),
    .branch_taken(branch_taken), .ext_stall(ext_stall),
    .pc_hold(pc_hold), .ir_hold(ir_hold), .dof_bubble(dof_bubble),
    .if_flush(if_flush), .dof_flush(dof_flush),
`ifdef HAZARD_PERF_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .state(state)
  );

  function automatic logic model_lu();
    logic reads_a, reads_b;
    reads_a = !MA && AA == DA_EXE;
    reads_b = !MB && BA == DA_EXE;
    return dof_valid && exe_valid && RW_EXE && MD_EXE == 2'b01 && DA_EXE != 0 && (reads_a || reads_b);
  endfunction

  task automatic idle();
    rst = 0; dof_valid = 0; AA = 0; BA = 0; MA = 0; MB = 0;
    exe_valid = 0; DA_EXE = 0; RW_EXE = 0; MD_EXE = 0;
    branch_taken = 0; ext_stall = 0;
  endtask

  task automatic set_load_use(input logic [RAW-1:0] a, input logic [RAW-1:0] d);
    idle();
    dof_valid = 1; AA = a; BA = 5'd9; MB = 1;
    exe_valid = 1; DA_EXE = d; RW_EXE = 1; MD_EXE = 2'b01;
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic cycle(input string tag);
    logic [6:0] obs, exp;
    logic e_pc, e_bub, e_if, e_dof;
    logic [1:0] e_st;
    #1;
    e_pc = 0; e_bub = 0; e_if = 0; e_dof = 0;
    e_st = (m_stall_left > 0) ? 2'b01 : (m_flush_left > 0) ? 2'b10 : 2'b00;
    if (rst) begin
      m_stall_left = 0;
      m_flush_left = 0;
    end else if (m_stall_left > 0) begin
      e_pc = 1; e_bub = 1;
      if (!ext_stall) m_stall_left--;
    end else if (m_flush_left > 0) begin
      e_if = 1; e_bub = 1;
      if (ext_stall) e_pc = 1;
      else m_flush_left--;
    end else if (ext_stall) begin
      e_pc = 1;
    end else if (branch_taken && exe_valid) begin
      e_if = 1; e_dof = 1; e_bub = 1;
      m_flush_left = BS - 1;
    end else if (model_lu()) begin
      e_pc = 1; e_bub = 1;
      m_stall_left = LL - 1;
    end
    obs = {state, pc_hold, ir_hold, dof_bubble, if_flush, dof_flush};
    exp = {e_st, e_pc, e_pc, e_bub, e_if, e_dof};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: {state,pc,ir,bub,iff,dff} observed=%b expected=%b", tag, obs, exp);
    end
    if (pc_hold === 1'b1) hold_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    // Reset
    cycle("reset0");
    rst = 1; cycle("reset1");
    idle(); cycle("post_reset");

    // Load-use on A: exactly LL hold cycles, then EXE carries the bubble.
    hold_cnt = 0;
    set_load_use(5'd3, 5'd3);
    cycle("lu_a_detect");
    exe_valid = 0; cycle("lu_a_stall");
    cycle("lu_a_resume");
    idle(); cycle("lu_a_idle");
    check_int("lu_a_hold_len", hold_cnt, LL);

    // No false hazards.
    hold_cnt = 0;
    set_load_use(5'd0, 5'd0); cycle("nohz_r0");
    set_load_use(5'd3, 5'd3); MA = 1; MB = 1; BA = 5'd3; cycle("nohz_mb");
    set_load_use(5'd3, 5'd3); MD_EXE = 2'b00; cycle("nohz_md");
    set_load_use(5'd3, 5'd3); RW_EXE = 0; cycle("nohz_rw");
    check_int("nohz_hold_len", hold_cnt, 0);

    // Taken branch concurrent with lu.
    hold_cnt = 0;
    set_load_use(5'd4, 5'd4); branch_taken = 1; cycle("br_lu_entry");
    idle(); cycle("br_shadow");
    cycle("br_done");
    check_int("br_no_hold", hold_cnt, 0);

    // ext_stall for 3 cycles during LOAD_STALL.
    hold_cnt = 0;
    set_load_use(5'd7, 5'd7); cycle("ext_detect");
    idle(); dof_valid = 1; AA = 5'd7;
    ext_stall = 1;
    for (int i = 0; i < 3; i++) cycle("ext_frozen");
    ext_stall = 0; cycle("ext_release");
    cycle("ext_resume");
    check_int("ext_hold_len", hold_cnt, LL + 3);

    // Reset the cycle after entering BR_FLUSH.
    idle(); exe_valid = 1; branch_taken = 1; cycle("rstbr_entry");
    idle(); rst = 1; cycle("rstbr_rst");
    idle(); cycle("rstbr_after");
    check_int("rstbr_state", int'(state), 0);

`ifdef HAZARD_PERF_EN
    idle(); rst = 1; cycle("perf_reset");
    idle();
    for (int k = 0; k < 2; k++) begin
      set_load_use(5'd5, 5'd5); cycle("perf_lu");
      exe_valid = 0; cycle("perf_lu_stall");
      idle(); cycle("perf_gap");
    end
    idle(); exe_valid = 1; branch_taken = 1; cycle("perf_br");
    idle(); cycle("perf_br_shadow");
    cycle("perf_idle");
    check_int("perf_stall_cycles", int'(stall_cycles), 4);
    check_int("perf_flush_events", int'(flush_events), 1);
`endif

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 63) == 0);
      dof_valid    = ($urandom_range(0, 3) != 0);
      AA           = RAW'($urandom_range(0, 3));
      BA           = RAW'($urandom_range(0, 3));
      MA           = ($urandom_range(0, 3) == 0);
      MB           = ($urandom_range(0, 3) == 0);
      exe_valid    = ($urandom_range(0, 3) != 0);
      DA_EXE       = RAW'($urandom_range(0, 3));
      RW_EXE       = ($urandom_range(0, 3) != 0);
      MD_EXE       = 2'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 7) == 0);
      ext_stall    = ($urandom_range(0, 5) == 0);
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
